ahb_slave_mem: RTL

AHB-Lite slave responder with a byte-addressable 32-bit word memory behind it. It is the target that our AHB master drives for single and INCR burst traffic.
- Accepts pipelined address and data phases.
- Inserts a programmable number of wait states.
- Raises a two-cycle ERROR response for illegal transfers.
- Lets master and bridge benches run without the APB side attached.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_slave_mem_array.sv | 35 +++
 rtl/ahb_slave_mem.sv | 119 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave responder state type.
// Imported by the slave memory top level and its storage sub-module.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Little-endian byte-lane enables for a transfer of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << lane;
      HSIZE_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word storage with byte-lane writes and a read port that forwards a
// write committing on the same edge, so a back-to-back read sees it.
module ahb_slave_mem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  // NOTE: storage has no reset; only control state needs a defined value,
  // and clearing a RAM would take a multi-cycle sequencer.
  logic [31:0] mem [DEPTH];
  logic [31:0] bit_mask;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign bit_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  assign rd_data = (we && (wr_idx == rd_idx))
                 ? ((wdata & bit_mask) | (mem[rd_idx] & ~bit_mask))
                 : mem[rd_idx];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave responder over a byte-addressable word memory, with
// programmable wait states and a two-cycle ERROR response.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic        hresp
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] WINDOW    = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES - 1);

  slave_state_e     state, state_d;
  logic [3:0]       wait_cnt;
  logic             a_write;
  logic [IDX_W-1:0] a_idx;
  logic [3:0]       a_be;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range, misaligned, illegal;
  logic             is_active, open_slot, accept, we;
  logic [31:0]      rd_data;

  assign offset     = haddr - BASE_ADDR;
  assign idx        = offset[IDX_W+1:2];
  assign in_range   = (haddr >= BASE_ADDR) && (offset < WINDOW);
  assign misaligned = ((hsize == HSIZE_HALF) && haddr[0])
                   || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  assign illegal    = !in_range || (hsize > HSIZE_WORD) || misaligned;

  // New address phases are sampled only in states that end a data phase.
  assign is_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign open_slot = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept    = hsel && hready_in && is_active && open_slot;

  assign we = (state == ST_DATA) && a_write && !hreset;

  // NOTE: every output gets a default first so no path leaves one unassigned.
  always_comb begin
    state_d    = state;
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      ST_WAIT: begin
        hready_out = 1'b0;
        if (wait_cnt == 4'd0) state_d = ST_DATA;
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
        state_d    = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        state_d = ST_IDLE;
        if (accept) begin
          if (illegal)               state_d = ST_ERR1;
          else if (WAIT_STATES > 0)  state_d = ST_WAIT;
          else                       state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      a_write  <= 1'b0;
      a_idx    <= '0;
      a_be     <= '0;
      hrdata   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_write  <= hwrite;
        a_idx    <= idx;
        a_be     <= lane_mask(hsize, haddr[1:0]);
        wait_cnt <= WAIT_INIT;
        // Read data is captured at accept so it is stable for the whole data phase.
        if (!hwrite && !illegal) hrdata <= rd_data;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  ahb_slave_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (hclk),
    .we      (we),
    .be      (a_be),
    .wr_idx  (a_idx),
    .wdata   (hwdata),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

endmodule
